// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage placed directly after the PC register. It takes the
// current PC and issues one fetch to a variable-latency instruction memory
// over a req/ack handshake. The fetched word is loaded into the IF/ID
// pipeline register. A stall is returned to the PC so that the PC advances
// only when a fetch completes, or when a flush redirects it to a new target.
//
// Ports
//   clk_i        : clock, all state updates on the rising edge
//   rst_i        : synchronous reset, active-low
//   start_i      : run enable; gates issue of new fetches from IDLE
//   pc_i         : current PC from the PC register
//   stall_i      : ID hazard stall; IF/ID contents hold
//   flush_i      : branch/jump taken; squash the in-flight fetch and IF/ID
//   pc_stall_o   : to the PC register; 1 = PC holds
//   imem_req_o   : instruction memory request (registered)
//   imem_addr_o  : request address (registered), stable while requesting
//   imem_ack_i   : memory response valid, honoured only while requesting
//   imem_data_i  : instruction word, valid with imem_ack_i
//   ifid_valid_o : IF/ID holds a real instruction
//   ifid_pc_o    : IF/ID instruction address
//   ifid_pc4_o   : IF/ID instruction address + 4 (wraps at 2^32)
//   ifid_insn_o  : IF/ID instruction word
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        pc_stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_insn_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_req;
    logic [31:0] r_addr;
    logic [31:0] r_hold_addr;
    logic [31:0] r_hold_data;

    logic        r_ifid_valid;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_insn;

    logic        w_issue;
    logic        w_capture;
    logic        w_fetch_done;
    logic [31:0] w_fetch_addr;
    logic [31:0] w_fetch_data;

    // ---- Stage p0: fetch control state register --------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            // The request is live in exactly the two states that wait on ack.
            r_req   <= (w_state_nxt == S_REQ) || (w_state_nxt == S_DISCARD);
            if (w_issue) begin
                r_addr <= pc_i;
            end
        end
    end

    // Next-state logic. At most one request is ever outstanding: a new one is
    // only issued from IDLE, which is entered only once the previous ack has
    // been consumed (or the request was killed by reset).
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    w_state_nxt = S_REQ;
                    w_issue     = 1'b1;
                end
            end
            S_REQ: begin
                if (imem_ack_i) begin
                    if (flush_i) begin
                        w_state_nxt = S_IDLE;
                    end else if (stall_i) begin
                        // ID cannot accept yet: park the word in the buffer.
                        w_state_nxt = S_HOLD;
                        w_capture   = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (flush_i) begin
                    // The memory still owes us an ack; wait it out and drop it.
                    w_state_nxt = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (flush_i || !stall_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_ack_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: which word (if any) completes this cycle, and whether the
    // PC may move. A flush always lets the PC load the redirect target.
    always_comb begin
        w_fetch_done = 1'b0;
        w_fetch_addr = r_hold_addr;
        w_fetch_data = r_hold_data;
        case (r_state)
            S_REQ: begin
                w_fetch_done = imem_ack_i && !stall_i && !flush_i;
                w_fetch_addr = r_addr;
                w_fetch_data = imem_data_i;
            end
            S_HOLD: begin
                w_fetch_done = !stall_i && !flush_i;
            end
            default: begin
                w_fetch_done = 1'b0;
            end
        endcase
        pc_stall_o = !flush_i && !w_fetch_done;
    end

    // ---- Stage p1: hold buffer and IF/ID register ------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_hold_addr <= 32'd0;
            r_hold_data <= 32'd0;
        end else if (w_capture) begin
            r_hold_addr <= r_addr;
            r_hold_data <= imem_data_i;
        end
    end

    // Flush beats stall beats a completed fetch; otherwise a bubble enters.
    // Bubbles and flushes leave the pc fields untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= 32'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_insn  <= NOP_INSN;
        end else if (flush_i) begin
            r_ifid_valid <= 1'b0;
            r_ifid_insn  <= NOP_INSN;
        end else if (!stall_i) begin
            if (w_fetch_done) begin
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= w_fetch_addr;
                r_ifid_pc4   <= w_fetch_addr + 32'd4;
                r_ifid_insn  <= w_fetch_data;
            end else begin
                r_ifid_valid <= 1'b0;
                r_ifid_insn  <= NOP_INSN;
            end
        end
    end

    assign imem_req_o   = r_req;
    assign imem_addr_o  = r_addr;
    assign ifid_valid_o = r_ifid_valid;
    assign ifid_pc_o    = r_ifid_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_insn_o  = r_ifid_insn;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Drives if_fetch_stage with a PC register model, a variable-wait memory
// model and directed plus randomized stall/flush/start traffic. The expected
// instruction stream is the sequential program order starting at the reset
// vector and restarting at every flush target; each word is addr|0xA5000000.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_pc4_o;
    logic [31:0] ifid_insn_o;

    if_fetch_stage #(.NOP_INSN(NOP)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .pc_i         (pc_i),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .pc_stall_o   (pc_stall_o),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_data_i  (imem_data_i),
        .ifid_valid_o (ifid_valid_o),
        .ifid_pc_o    (ifid_pc_o),
        .ifid_pc4_o   (ifid_pc4_o),
        .ifid_insn_o  (ifid_insn_o)
    );

    always #5 clk_i = ~clk_i;

    // Stimulus-side knobs
    logic [31:0] tgt;          // reset vector / flush target
    int          mem_wait_mode; // <0 random 0..3, else fixed wait count
    bit          force_data;   // memory answers 0xDEADBEEF
    bit          force_ack;    // stray ack with no request
    bit          done;
    int          tmo_cnt;

    // PC register: loads the target on reset/flush, else advances when allowed.
    always @(posedge clk_i) begin
        if (!rst_i || flush_i) pc_i <= tgt;
        else if (!pc_stall_o)  pc_i <= pc_i + 32'd4;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a | 32'hA500_0000;
    endfunction

    // Memory model: answers each request after cur_wait cycles.
    initial begin
        int cnt;
        int cur_wait;
        cnt = 0;
        cur_wait = 0;
        imem_ack_i  = 1'b0;
        imem_data_i = 32'd0;
        forever begin
            @(posedge clk_i);
            #2;
            imem_ack_i  = 1'b0;
            imem_data_i = $urandom;
            if (imem_req_o) begin
                if (cnt >= cur_wait) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = force_data ? 32'hDEAD_BEEF : mem_word(imem_addr_o);
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                cur_wait = (mem_wait_mode < 0) ? int'($urandom_range(0, 3)) : mem_wait_mode;
            end
            if (force_ack) begin
                imem_ack_i  = 1'b1;
                imem_data_i = 32'h1234_5678;
            end
        end
    end

    // Scoreboard
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] insn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   loads  = 0;

    function automatic exp_t mk(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.pc4  = a + 32'd4;
        e.insn = mem_word(a);
        return e;
    endfunction

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(a + 32'(4 * i)));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: at each falling edge judge what the last rising edge produced,
    // using the inputs and outputs recorded one falling edge earlier.
    bit          have_prev = 1'b0;
    logic        p_rst, p_flush, p_stall, p_pcstall, p_req, p_ack, p_valid;
    logic [31:0] p_addr, p_pc, p_pc4, p_insn, p_tgt;
    exp_t        e;

    always @(negedge clk_i) begin
        if (have_prev) begin
            if (!p_rst) begin
                chk1 ("rst_req",   imem_req_o,   1'b0);
                chk32("rst_addr",  imem_addr_o,  32'd0);
                chk1 ("rst_valid", ifid_valid_o, 1'b0);
                chk32("rst_pc",    ifid_pc_o,    32'd0);
                chk32("rst_pc4",   ifid_pc4_o,   32'd0);
                chk32("rst_insn",  ifid_insn_o,  NOP);
                restart(p_tgt);
            end else begin
                if (p_req && !p_ack) begin
                    chk1 ("req_held",    imem_req_o,  1'b1);
                    chk32("addr_stable", imem_addr_o, p_addr);
                end
                if (p_flush) begin
                    chk1 ("flush_valid",   ifid_valid_o, 1'b0);
                    chk32("flush_insn",    ifid_insn_o,  NOP);
                    chk32("flush_pc",      ifid_pc_o,    p_pc);
                    chk32("flush_pc4",     ifid_pc4_o,   p_pc4);
                    chk1 ("flush_pcstall", p_pcstall,    1'b0);
                    restart(p_tgt);
                end else if (p_stall) begin
                    chk1 ("stall_valid",   ifid_valid_o, p_valid);
                    chk32("stall_pc",      ifid_pc_o,    p_pc);
                    chk32("stall_pc4",     ifid_pc4_o,   p_pc4);
                    chk32("stall_insn",    ifid_insn_o,  p_insn);
                    chk1 ("stall_pcstall", p_pcstall,    1'b1);
                end else if (ifid_valid_o) begin
                    loads++;
                    chk1("load_pcstall", p_pcstall, 1'b0);
                    if (exp_q.size() == 0) begin
                        chk32("load_unexpected", ifid_pc_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        exp_q.push_back(mk(exp_q[$].pc + 32'd4));
                        chk32("load_pc",   ifid_pc_o,   e.pc);
                        chk32("load_pc4",  ifid_pc4_o,  e.pc4);
                        chk32("load_insn", ifid_insn_o, e.insn);
                    end
                end else begin
                    chk32("bubble_insn",    ifid_insn_o, NOP);
                    chk32("bubble_pc",      ifid_pc_o,   p_pc);
                    chk32("bubble_pc4",     ifid_pc4_o,  p_pc4);
                    chk1 ("bubble_pcstall", p_pcstall,   1'b1);
                end
            end
        end
        have_prev = 1'b1;
        p_rst     = rst_i;
        p_flush   = flush_i;
        p_stall   = stall_i;
        p_pcstall = pc_stall_o;
        p_req     = imem_req_o;
        p_ack     = imem_ack_i;
        p_addr    = imem_addr_o;
        p_valid   = ifid_valid_o;
        p_pc      = ifid_pc_o;
        p_pc4     = ifid_pc4_o;
        p_insn    = ifid_insn_o;
        p_tgt     = tgt;
        if (done) begin
            chk32("wait_timeouts", 32'(tmo_cnt), 32'd0);
            checks++;
            if (loads < 100) begin
                errors++;
                $display("FAIL progress: loads %0d required at least 100", loads);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Returns inside the first REQ cycle of a fresh request.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req_o && n < 50) begin tick(); n++; end
        while (!imem_req_o && n < 50) begin tick(); n++; end
        if (!imem_req_o) tmo_cnt++;
    endtask

    initial begin
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        tgt = 32'd0; mem_wait_mode = 0; force_data = 1'b0; force_ack = 1'b0;
        done = 1'b0; tmo_cnt = 0;
        repeat (2) tick();
        rst_i = 1'b1;
        start_i = 1'b1;

        // zero-wait streaming from 0x0
        repeat (10) tick();

        // redirect to 0x40 with a 3-wait memory
        mem_wait_mode = 3;
        tgt = 32'h40; flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (20) tick();

        // stall on the ack cycle, held for two more cycles
        mem_wait_mode = 0;
        wait_req();
        stall_i = 1'b1;
        repeat (3) tick();
        stall_i = 1'b0;
        repeat (6) tick();

        // flush while waiting; the late 0xDEADBEEF must be dropped
        mem_wait_mode = 2;
        wait_req();
        force_data = 1'b1;
        tgt = 32'h100; flush_i = 1'b1; tick(); flush_i = 1'b0;
        begin
            int n;
            n = 0;
            while (imem_req_o && n < 20) begin tick(); n++; end
            if (imem_req_o) tmo_cnt++;
        end
        force_data = 1'b0;
        repeat (10) tick();

        // flush coinciding with ack, then run across the address wrap
        mem_wait_mode = 0;
        wait_req();
        tgt = 32'hFFFF_FFF8; flush_i = 1'b1; tick(); flush_i = 1'b0;
        repeat (10) tick();

        // reset in the middle of a request, then a stray ack
        mem_wait_mode = 3;
        wait_req();
        tgt = 32'h200; rst_i = 1'b0; tick(); rst_i = 1'b1;
        start_i = 1'b0; force_ack = 1'b1; tick(); force_ack = 1'b0;
        tick();
        start_i = 1'b1; mem_wait_mode = 0;
        repeat (8) tick();

        // randomized traffic
        mem_wait_mode = -1;
        for (int c = 0; c < 1500; c++) begin
            start_i = ($urandom_range(0, 7) != 0);
            stall_i = ($urandom_range(0, 3) == 0);
            flush_i = ($urandom_range(0, 24) == 0);
            if (flush_i) begin
                case ($urandom_range(0, 3))
                    0: tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
                    1: tgt = $urandom;
                    default: tgt = $urandom & 32'hFFFF_FFFC;
                endcase
            end
            tick();
        end
        start_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        repeat (10) tick();
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
